seq_div16x8: RTL and testbench

Sequential restoring divider. Divides a 16-bit dividend by an 8-bit divisor, one quotient bit per clock, and returns a 16-bit quotient and an 8-bit remainder. It is the inverse datapath companion to the 8x8 sequential multiplier. It uses the same start/done_flag handshake, so the same controller and bench infrastructure can drive it.

---
 rtl/seq_div16x8.sv | 221 ++++++++++++++++++++++
 tb/tb_seq_div16x8.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_div16x8.sv
// -----------------------------------------------------------------------------
// seq_div16x8 -- sequential restoring divider, one quotient bit per clock.
//
// Divides a DW-bit dividend by a VW-bit divisor and returns a DW-bit quotient
// and a VW-bit remainder. Uses the same start / done_flag handshake as the 8x8
// sequential multiplier.
//
// Timing (unsigned build): the accept edge loads the operands. The next DW
// edges each produce one quotient bit. One more edge publishes the result, so
// done_flag rises DW+1 edges after the accept edge. Divide-by-zero skips the
// iterations and publishes on the edge after the accept edge.
//
// Optional feature, selected by the macro DIV_SIGNED_EN:
//   The operands are treated as two's complement. The magnitudes are divided
//   unsigned. A single FIX cycle then restores the signs: the quotient
//   truncates toward zero and the remainder takes the sign of the dividend.
//   Latency becomes DW+2.
//
// Ports:
//   clk          rising-edge clock
//   reset_a      asynchronous active-low reset
//   start        request; ignored while busy
//   dividend     DW-bit dividend, latched on accept
//   divisor      VW-bit divisor, latched on accept
//   quotient     DW-bit result quotient (registered, held while done_flag=1)
//   remainder    VW-bit result remainder (registered, held while done_flag=1)
//   done_flag    result valid; held until the next accepted start
//   busy         high from accept until the result is published
//   div_by_zero  set together with done_flag when the divisor was 0
// -----------------------------------------------------------------------------
module seq_div16x8 #(
  parameter int DW = 16,  // dividend / quotient width
  parameter int VW = 8    // divisor / remainder width, must not exceed DW
) (
  input  logic          clk,
  input  logic          reset_a,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          done_flag,
  output logic          busy,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t state, state_nxt;

  // Working registers
  logic [VW:0]   rem_q,   rem_d;    // partial remainder
  logic [DW-1:0] shift_q, shift_d;  // dividend bits shift out, quotient bits shift in
  logic [VW-1:0] dvs_q,   dvs_d;    // latched divisor (magnitude)
  logic [CW-1:0] cnt_q,   cnt_d;    // remaining iterations minus one
  logic          zero_q,  zero_d;   // latched divisor was zero

  // Output register next values
  logic [DW-1:0] quotient_d;
  logic [VW-1:0] remainder_d;
  logic          done_d, busy_d, dbz_d;

  logic          accept;
  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;
  logic [VW:0]   trial;
  logic          ge;

  // busy already covers CALC, FIX and the cycle that publishes the result,
  // so a start request in any of those cycles is ignored.
  assign accept = start && !busy;

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_q_d;  // quotient must be negated
  logic neg_r_q, neg_r_d;  // remainder must be negated

  // -(-2^(DW-1)) wraps to 2^(DW-1), which is still the correct unsigned
  // magnitude, so the most negative operands need no special case.
  assign dvd_mag = dividend[DW-1] ? -dividend : dividend;
  assign dvs_mag = divisor[VW-1]  ? -divisor  : divisor;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  assign trial = {rem_q[VW-1:0], shift_q[DW-1]};
  assign ge    = (trial >= {1'b0, dvs_q});

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_a) begin
    // NOTE: non-blocking assignments in clocked blocks keep every register
    // reading the pre-edge value of its neighbours, independent of block order.
    if (!reset_a) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default assignment first means that every path assigns the
    // signal, so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = (divisor == '0) ? DONE : CALC;
`ifdef DIV_SIGNED_EN
      CALC:       if (cnt_q == '0) state_nxt = FIX;
      FIX:        state_nxt = DONE;
`else
      CALC:       if (cnt_q == '0) state_nxt = DONE;
`endif
      default:    state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath / output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    rem_d       = rem_q;
    shift_d     = shift_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    quotient_d  = quotient;
    remainder_d = remainder;
    done_d      = done_flag;
    busy_d      = busy;
    dbz_d       = div_by_zero;
`ifdef DIV_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
`endif
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          rem_d   = '0;
          shift_d = dvd_mag;
          dvs_d   = dvs_mag;
          cnt_d   = CW'(DW - 1);
          zero_d  = (divisor == '0);
          done_d  = 1'b0;
          dbz_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef DIV_SIGNED_EN
          neg_q_d = dividend[DW-1] ^ divisor[VW-1];
          neg_r_d = dividend[DW-1];
`endif
        end else if (state == DONE && busy) begin
          // The first DONE cycle publishes the finished result.
          // The outputs then stay unchanged until the next accept.
          quotient_d  = zero_q ? '1 : shift_q;
          remainder_d = zero_q ? '0 : rem_q[VW-1:0];
          dbz_d       = zero_q;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end
      end
      CALC: begin
        rem_d   = ge ? (trial - {1'b0, dvs_q}) : trial;
        shift_d = {shift_q[DW-2:0], ge};
        cnt_d   = cnt_q - 1'b1;
      end
`ifdef DIV_SIGNED_EN
      FIX: begin
        shift_d = neg_q_q ? -shift_q : shift_q;
        rem_d   = neg_r_q ? -rem_q   : rem_q;
      end
`endif
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath / output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_a) begin
    // NOTE: every register is reset, including the working state. This makes
    // a reset in the middle of CALC leave no partial result behind.
    if (!reset_a) begin
      rem_q       <= '0;
      shift_q     <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done_flag   <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      rem_q       <= rem_d;
      shift_q     <= shift_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      done_flag   <= done_d;
      busy        <= busy_d;
      div_by_zero <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_div16x8.sv
// -----------------------------------------------------------------------------
// tb_seq_div16x8 -- self-checking bench for seq_div16x8.
//
// Directed cases and randomized operands are compared against a plain
// arithmetic reference built from '/' and '%'. The bench also checks the
// handshake: latency, busy, done_flag, ignored starts, and the asynchronous
// reset. The reference model and the latency follow DIV_SIGNED_EN when that
// macro is defined.
// -----------------------------------------------------------------------------
module tb_seq_div16x8;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done_flag, busy, div_by_zero;

  int checks = 0;
  int errors = 0;

`ifdef DIV_SIGNED_EN
  localparam int CALC_LAT = 18;
`else
  localparam int CALC_LAT = 17;
`endif

  always #5 clk = ~clk;

  seq_div16x8 #(.DW(16), .VW(8)) dut (
    .clk         (clk),
    .reset_a     (reset_a),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done_flag   (done_flag),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer division.
  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r);
`ifdef DIV_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = 16'hFFFF; r = 8'h00;
    end else if (sa == -32768 && sb == -1) begin
      q = 16'h8000; r = 8'h00;
    end else begin
      q = 16'(sa / sb);
      r = 8'(sa % sb);
    end
`else
    if (b == 8'h00) begin
      q = 16'hFFFF; r = 8'h00;
    end else begin
      q = a / 16'(b);
      r = 8'(a % 16'(b));
    end
`endif
  endtask

  // Present a start for one edge. Returns #1 after the accept edge.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Run one division and check it against the model.
  // pulse_at > 0 presents a second start at that edge, which must be ignored.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input int pulse_at);
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    int          n;
    int          exp_lat;
    model(a, b, exp_q, exp_r);
    exp_lat = (b == 8'h00) ? 1 : CALC_LAT;
    start_op(a, b);
    check({tag, ".done_drop"}, 32'(done_flag), 32'd0);
    check({tag, ".busy_set"},  32'(busy),      32'd1);
    n = 0;
    do begin
      if (pulse_at > 0 && n == pulse_at - 1) begin
        start    = 1'b1;
        dividend = 16'h0001;
        divisor  = 8'h01;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end while (!done_flag && n < 40);
    check({tag, ".done"},    32'(done_flag),   32'd1);
    check({tag, ".latency"}, 32'(n),           32'(exp_lat));
    check({tag, ".q"},       32'(quotient),    32'(exp_q));
    check({tag, ".r"},       32'(remainder),   32'(exp_r));
    check({tag, ".dbz"},     32'(div_by_zero), 32'(b == 8'h00));
    check({tag, ".busy"},    32'(busy),        32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    reset_a  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.q",    32'(quotient),    32'd0);
    check("reset.r",    32'(remainder),   32'd0);
    check("reset.done", 32'(done_flag),   32'd0);
    check("reset.busy", 32'(busy),        32'd0);
    check("reset.dbz",  32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset_a = 1'b1;

    // Directed unsigned cases
    run_div("d1000_7",   16'h03E8, 8'h07, 0);
    run_div("dffff_ff",  16'hFFFF, 8'hFF, 0);
    run_div("d5_9",      16'h0005, 8'h09, 0);
    run_div("div0",      16'h00FF, 8'h00, 0);

    // Result must hold while idle in DONE
    repeat (3) @(posedge clk);
    #1;
    check("hold.q",    32'(quotient),    32'h0000FFFF);
    check("hold.done", 32'(done_flag),   32'd1);
    check("hold.dbz",  32'(div_by_zero), 32'd1);

    // A start while busy is ignored
    run_div("ignored_start", 16'h1234, 8'h10, 5);

    // Reset in the middle of CALC
    start_op(16'h1234, 8'h10);
    repeat (8) @(posedge clk);
    #1;
    reset_a = 1'b0;
    #1;
    check("midrst.q",    32'(quotient),    32'd0);
    check("midrst.r",    32'(remainder),   32'd0);
    check("midrst.done", 32'(done_flag),   32'd0);
    check("midrst.busy", 32'(busy),        32'd0);
    check("midrst.dbz",  32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset_a = 1'b1;
    run_div("after_rst", 16'h0064, 8'h0A, 0);

`ifdef DIV_SIGNED_EN
    run_div("s_neg100_7",  16'hFF9C, 8'h07, 0);
    run_div("s_ovf",       16'h8000, 8'hFF, 0);
`endif

    // Randomized operands, with an occasional zero divisor
    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_div($sformatf("rand%0d", i), ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
